// File: rtl/puf_pkg.sv
// Shared types, default parameters and width helper for the PUF evaluation scheduler.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_RESULT
    } state_t;

    localparam int unsigned DEF_CHALLENGE_WIDTH  = 64;
    localparam int unsigned DEF_PDL_CONFIG_WIDTH = 64;
    localparam int unsigned DEF_RESPONSE_WIDTH   = 6;
    localparam int unsigned DEF_NUM_EVALS        = 15;
    localparam int unsigned DEF_GAP_CYCLES       = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 64;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_eval_scheduler_if.sv
// Host-side command/response channel of the PUF evaluation scheduler.
interface puf_eval_scheduler_if #(
    parameter int unsigned CHALLENGE_WIDTH  = puf_pkg::DEF_CHALLENGE_WIDTH,
    parameter int unsigned PDL_CONFIG_WIDTH = puf_pkg::DEF_PDL_CONFIG_WIDTH,
    parameter int unsigned RESPONSE_WIDTH   = puf_pkg::DEF_RESPONSE_WIDTH,
    parameter int unsigned NUM_EVALS        = puf_pkg::DEF_NUM_EVALS
);
    localparam int unsigned CW = puf_pkg::cnt_width(NUM_EVALS);

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [CHALLENGE_WIDTH-1:0]  cmd_challenge;
    logic [PDL_CONFIG_WIDTH-1:0] cmd_pdl_config;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic                        rsp_xor;
    logic [RESPONSE_WIDTH-1:0]   rsp_raw;
    logic [CW-1:0]               rsp_xor_ones;
    logic                        rsp_timeout;

    modport master (
        output cmd_valid, cmd_challenge, cmd_pdl_config, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_xor, rsp_raw, rsp_xor_ones, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_challenge, cmd_pdl_config, rsp_ready,
        output cmd_ready, rsp_valid, rsp_xor, rsp_raw, rsp_xor_ones, rsp_timeout
    );

endinterface

// File: rtl/puf_eval_scheduler_majority_acc.sv
// Per-bit vote accumulator: counts ones across evaluations and reports the majority.
module majority_acc #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_EVALS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] cnt,
    output logic             maj
);

    // Count ones; clear has priority so a new command starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && bit_in) begin
            cnt <= cnt + 1'b1;
        end
    end

    // NUM_EVALS is odd, so a strict compare against half can never tie.
    assign maj = (cnt > WIDTH'(NUM_EVALS / 2));

endmodule

// File: rtl/puf_eval_scheduler.sv
// Issues NUM_EVALS triggers to the PUF per command and majority-votes the responses.
module puf_eval_scheduler
    import puf_pkg::*;
#(
    parameter int unsigned CHALLENGE_WIDTH  = DEF_CHALLENGE_WIDTH,
    parameter int unsigned PDL_CONFIG_WIDTH = DEF_PDL_CONFIG_WIDTH,
    parameter int unsigned RESPONSE_WIDTH   = DEF_RESPONSE_WIDTH,
    parameter int unsigned NUM_EVALS        = DEF_NUM_EVALS,
    parameter int unsigned GAP_CYCLES       = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    puf_eval_scheduler_if.slave         host,
    output logic                        busy,
    output logic                        puf_trigger,
    output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
    output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
    input  logic                        puf_done,
    input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
    input  logic                        puf_xor_response
);

    localparam int unsigned    CW        = cnt_width(NUM_EVALS);
    localparam int unsigned    WW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  EVAL_LAST = CW'(NUM_EVALS);
    localparam logic [WW-1:0]  WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    if ((NUM_EVALS < 1) || ((NUM_EVALS % 2) == 0)) begin : g_bad_evals
        $error("puf_eval_scheduler: NUM_EVALS must be odd and at least 1");
    end
    if (GAP_CYCLES > 15) begin : g_bad_gap
        $error("puf_eval_scheduler: GAP_CYCLES must be in 0..15");
    end
    if (TIMEOUT_CYCLES <= 16) begin : g_bad_timeout
        $error("puf_eval_scheduler: TIMEOUT_CYCLES must exceed 16");
    end

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       eval_cnt;
    logic [WW-1:0]       wdog;
    logic [3:0]          gap_cnt;
    logic                rsp_valid_q;
    logic                rsp_timeout_q;

    logic                accept;
    logic                handshake;
    logic                timeout_hit;
    logic                acc_clr;
    logic                acc_en;

    logic [CW-1:0]       xor_cnt;
    logic                xor_maj;
    logic [CW-1:0]       raw_cnt [RESPONSE_WIDTH];
    logic [RESPONSE_WIDTH-1:0] raw_maj;

    assign accept      = (state == ST_IDLE) && host.cmd_valid;
    assign handshake   = (state == ST_RESULT) && host.rsp_ready;
    assign timeout_hit = (state == ST_WAIT) && !puf_done && (wdog == WD_LAST);
    // Clearing on timeout is what forces the reported vote fields to zero.
    assign acc_clr     = accept || timeout_hit;
    assign acc_en      = (state == ST_WAIT) && puf_done;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; a completion in WAIT takes priority over the watchdog.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (host.cmd_valid) state_next = ST_ISSUE;
            ST_ISSUE:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (puf_done) begin
                    if (eval_cnt == EVAL_LAST) state_next = ST_RESULT;
                    else if (GAP_CYCLES == 0)  state_next = ST_ISSUE;
                    else                       state_next = ST_GAP;
                end else if (wdog == WD_LAST) begin
                    state_next = ST_RESULT;
                end
            end
            ST_GAP:    if (gap_cnt == GAP_LAST) state_next = ST_ISSUE;
            ST_RESULT: if (host.rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        host.cmd_ready = 1'b0;
        busy           = 1'b1;
        puf_trigger    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                host.cmd_ready = 1'b1;
                busy           = 1'b0;
            end
            ST_ISSUE: puf_trigger = 1'b1;
            default: ;
        endcase
    end

    // Command latch, evaluation/watchdog/gap counters and registered response flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            puf_challenge  <= '0;
            puf_pdl_config <= '0;
            eval_cnt       <= '0;
            wdog           <= '0;
            gap_cnt        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            if (accept) begin
                puf_challenge  <= host.cmd_challenge;
                puf_pdl_config <= host.cmd_pdl_config;
                eval_cnt       <= '0;
                wdog           <= '0;
            end
            if (state == ST_ISSUE) begin
                eval_cnt <= eval_cnt + 1'b1;
                wdog     <= '0;
            end else if ((state == ST_WAIT) && !puf_done) begin
                wdog <= wdog + 1'b1;
            end
            gap_cnt     <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            rsp_valid_q <= (state_next == ST_RESULT);
            if (timeout_hit) begin
                rsp_timeout_q <= 1'b1;
            end else if (handshake) begin
                rsp_timeout_q <= 1'b0;
            end
        end
    end

    majority_acc #(.WIDTH(CW), .NUM_EVALS(NUM_EVALS)) u_xor_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (puf_xor_response),
        .cnt    (xor_cnt),
        .maj    (xor_maj)
    );

    for (genvar i = 0; i < RESPONSE_WIDTH; i++) begin : g_raw
        majority_acc #(.WIDTH(CW), .NUM_EVALS(NUM_EVALS)) u_raw_acc (
            .clk    (clk),
            .reset  (reset),
            .clr    (acc_clr),
            .en     (acc_en),
            .bit_in (puf_raw_response[i]),
            .cnt    (raw_cnt[i]),
            .maj    (raw_maj[i])
        );
    end

    // Accumulators see at most NUM_EVALS increments per command, so they never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (xor_cnt <= EVAL_LAST);
            for (int unsigned i = 0; i < RESPONSE_WIDTH; i++) begin
                assert (raw_cnt[i] <= EVAL_LAST);
            end
        end
    end

    // Accumulators hold still in RESULT; fields read zero whenever no result is presented.
    assign host.rsp_valid    = rsp_valid_q;
    assign host.rsp_timeout  = rsp_timeout_q;
    assign host.rsp_xor      = rsp_valid_q & xor_maj;
    assign host.rsp_raw      = rsp_valid_q ? raw_maj : '0;
    assign host.rsp_xor_ones = rsp_valid_q ? xor_cnt : '0;

endmodule

// File: tb/tb_puf_eval_scheduler.sv
// Directed bench: three schedulers (GAP 2, 0, 3) driven by a behavioural PUF model.
module tb_puf_eval_scheduler;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Host-side stimulus and observed outputs, one slot per DUT.
    logic        cmd_valid [3];
    logic [63:0] cmd_ch    [3];
    logic [63:0] cmd_cfg   [3];
    logic        rsp_ready [3];
    logic        cmd_ready [3];
    logic        rsp_valid [3];
    logic        rsp_xor   [3];
    logic        rsp_to    [3];
    logic [5:0]  rsp_raw   [3];
    logic [3:0]  rsp_ones  [3];
    logic        busy      [3];
    logic        trig      [3];
    logic [63:0] pch       [3];
    logic [63:0] pcfg      [3];

    // PUF model signals and state.
    logic        done      [3];
    logic        real_done [3];
    logic        xr        [3];
    logic [5:0]  rr        [3];
    int          pend      [3] = '{0, 0, 0};
    int          cur       [3] = '{0, 0, 0};
    int          eidx      [3] = '{0, 0, 0};
    int          ntrig     [3] = '{0, 0, 0};
    int          dcyc      [3] = '{0, 0, 0};
    int          sp_min    [3] = '{999, 999, 999};
    int          sp_max    [3] = '{0, 0, 0};
    logic        have_done [3] = '{1'b0, 1'b0, 1'b0};
    logic        spur_q    [3] = '{1'b0, 1'b0, 1'b0};
    int          cyc = 0;

    // Model configuration written only by the stimulus block.
    logic        hang      [3] = '{1'b0, 1'b0, 1'b0};
    logic        spur_en   [3] = '{1'b0, 1'b0, 1'b1};
    logic [14:0] xpat      [3];
    logic [5:0]  rawpat    [3][15];

    localparam int DLY = 3;

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        puf_eval_scheduler_if #(
            .CHALLENGE_WIDTH  (64),
            .PDL_CONFIG_WIDTH (64),
            .RESPONSE_WIDTH   (6),
            .NUM_EVALS        (15)
        ) hif ();

        assign hif.cmd_valid      = cmd_valid[g];
        assign hif.cmd_challenge  = cmd_ch[g];
        assign hif.cmd_pdl_config = cmd_cfg[g];
        assign hif.rsp_ready      = rsp_ready[g];
        assign cmd_ready[g]       = hif.cmd_ready;
        assign rsp_valid[g]       = hif.rsp_valid;
        assign rsp_xor[g]         = hif.rsp_xor;
        assign rsp_raw[g]         = hif.rsp_raw;
        assign rsp_ones[g]        = hif.rsp_xor_ones;
        assign rsp_to[g]          = hif.rsp_timeout;

        puf_eval_scheduler #(
            .CHALLENGE_WIDTH  (64),
            .PDL_CONFIG_WIDTH (64),
            .RESPONSE_WIDTH   (6),
            .NUM_EVALS        (15),
            .GAP_CYCLES       (g == 0 ? 2 : (g == 1 ? 0 : 3)),
            .TIMEOUT_CYCLES   (64)
        ) dut (
            .clk              (clk),
            .reset            (rst_n),
            .host             (hif),
            .busy             (busy[g]),
            .puf_trigger      (trig[g]),
            .puf_challenge    (pch[g]),
            .puf_pdl_config   (pcfg[g]),
            .puf_done         (done[g]),
            .puf_raw_response (rr[g]),
            .puf_xor_response (xr[g])
        );
    end

    // PUF responses: real done DLY-1 cycles after the trigger is seen; spurious done forces all ones.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            real_done[k] = (pend[k] == 1) && !hang[k];
            done[k]      = real_done[k] || spur_q[k];
            xr[k]        = spur_q[k] ? 1'b1 : xpat[k][cur[k]];
            rr[k]        = spur_q[k] ? 6'b111111 : rawpat[k][cur[k]];
        end
    end

    // PUF model sequencing plus done-to-trigger spacing measurement.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (cmd_valid[k] && cmd_ready[k]) begin
                eidx[k]      <= 0;
                have_done[k] <= 1'b0;
                sp_min[k]    <= 999;
                sp_max[k]    <= 0;
            end
            if (trig[k]) begin
                cur[k]   <= eidx[k];
                eidx[k]  <= eidx[k] + 1;
                ntrig[k] <= ntrig[k] + 1;
                pend[k]  <= DLY;
                if (have_done[k]) begin
                    if (cyc - dcyc[k] < sp_min[k]) sp_min[k] <= cyc - dcyc[k];
                    if (cyc - dcyc[k] > sp_max[k]) sp_max[k] <= cyc - dcyc[k];
                end
            end else if (pend[k] > 0) begin
                pend[k] <= pend[k] - 1;
            end
            spur_q[k] <= spur_en[k] && real_done[k];
            if (real_done[k]) begin
                dcyc[k]      <= cyc;
                have_done[k] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_pat(input int k, input logic [14:0] xp, input logic [5:0] ra, input logic [5:0] rb);
        xpat[k] = xp;
        for (int e = 0; e < 15; e++) rawpat[k][e] = (e < 8) ? ra : rb;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first trigger cycle.
    task automatic run_cmd(input int k, input logic [63:0] ch, input logic [63:0] cfg);
        cmd_ch[k]    = ch;
        cmd_cfg[k]   = cfg;
        cmd_valid[k] = 1'b1;
        @(negedge clk);
        cmd_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k);
        int n;
        n = 0;
        while (rsp_valid[k] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("rsp_arrives_%0d", k), {63'd0, rsp_valid[k]}, 64'd1);
    endtask

    initial begin
        int n0;
        int n;
        int bad;
        int rdy_seen;
        int trg_seen;
        logic [12:0] snap;
        logic [63:0] snap_ch;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_ch[k]    = '0;
            cmd_cfg[k]   = '0;
            rsp_ready[k] = 1'b1;
            set_pat(k, 15'h01FF, 6'b101010, 6'b101010);
        end
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_cmd_ready", {63'd0, cmd_ready[0]}, 64'd1);
        chk("rst_busy",      {63'd0, busy[0]},      64'd0);
        chk("rst_trigger",   {63'd0, trig[0]},      64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
        chk("rst_fields",    {50'd0, rsp_xor[0], rsp_raw[0], rsp_ones[0], rsp_to[0], 1'b0}, 64'd0);
        chk("rst_puf_ch",    pch[0],  64'd0);
        chk("rst_puf_cfg",   pcfg[0], 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 9 of 15 xor ones, raw constant 101010.
        n0 = ntrig[0];
        run_cmd(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        chk("t1_first_trigger", {63'd0, trig[0]},      64'd1);
        chk("t1_busy",          {63'd0, busy[0]},      64'd1);
        chk("t1_cmd_ready",     {63'd0, cmd_ready[0]}, 64'd0);
        chk("t1_puf_ch",        pch[0],  64'h0123_4567_89AB_CDEF);
        chk("t1_puf_cfg",       pcfg[0], 64'hFEDC_BA98_7654_3210);
        wait_rsp(0);
        chk("t1_xor",     {63'd0, rsp_xor[0]},  64'd1);
        chk("t1_ones",    {60'd0, rsp_ones[0]}, 64'd9);
        chk("t1_raw",     {58'd0, rsp_raw[0]},  64'h2A);
        chk("t1_timeout", {63'd0, rsp_to[0]},   64'd0);
        chk("t1_ntrig",   64'(ntrig[0] - n0),   64'd15);
        @(negedge clk);
        chk("t1_released", {62'd0, rsp_valid[0], cmd_ready[0]}, 64'd1);

        // 7 of 15 xor ones; raw bits 0 and 5 set on 8 evals, bits 1..4 on 7.
        set_pat(0, 15'h007F, 6'b100001, 6'b011110);
        n0 = ntrig[0];
        run_cmd(0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        wait_rsp(0);
        chk("t2_xor",   {63'd0, rsp_xor[0]},  64'd0);
        chk("t2_ones",  {60'd0, rsp_ones[0]}, 64'd7);
        chk("t2_raw",   {58'd0, rsp_raw[0]},  64'h21);
        chk("t2_ntrig", 64'(ntrig[0] - n0),   64'd15);
        @(negedge clk);

        // Back-pressure: result held for 20 cycles while cmd_valid toggles.
        set_pat(0, 15'h01FF, 6'b101010, 6'b101010);
        rsp_ready[0] = 1'b0;
        run_cmd(0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_CAFE_F00D);
        wait_rsp(0);
        snap    = {rsp_xor[0], rsp_raw[0], rsp_ones[0], rsp_to[0], rsp_valid[0]};
        snap_ch = pch[0];
        bad = 0; rdy_seen = 0; trg_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cmd_valid[0] = ~cmd_valid[0];
            cmd_ch[0]    = {$urandom, $urandom};
            @(negedge clk);
            if ({rsp_xor[0], rsp_raw[0], rsp_ones[0], rsp_to[0], rsp_valid[0]} !== snap) bad++;
            if (pch[0] !== snap_ch) bad++;
            if (cmd_ready[0] !== 1'b0) rdy_seen++;
            if (trig[0] !== 1'b0) trg_seen++;
        end
        chk("hold_snapshot", {51'd0, snap}, {51'd0, 1'b1, 6'b101010, 4'd9, 1'b0, 1'b1});
        chk("hold_stable",   64'(bad),      64'd0);
        chk("hold_no_ready", 64'(rdy_seen), 64'd0);
        chk("hold_no_trig",  64'(trg_seen), 64'd0);
        cmd_valid[0] = 1'b1;
        cmd_ch[0]    = 64'hA5A5_5A5A_A5A5_5A5A;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("hs_idle_ready", {62'd0, rsp_valid[0], cmd_ready[0]}, 64'd1);
        chk("hs_not_taken",  pch[0], 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        chk("hs_next_trig", {63'd0, trig[0]}, 64'd1);
        chk("hs_next_ch",   pch[0], 64'hA5A5_5A5A_A5A5_5A5A);
        wait_rsp(0);
        chk("hs_next_ones", {60'd0, rsp_ones[0]}, 64'd9);
        @(negedge clk);

        // Hung PUF: watchdog abort.
        hang[0] = 1'b1;
        run_cmd(0, 64'h0BAD_0BAD_0BAD_0BAD, 64'h1);
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", 64'(n), 64'd65);
        chk("to_flag",    {63'd0, rsp_to[0]}, 64'd1);
        chk("to_fields",  {53'd0, rsp_xor[0], rsp_raw[0], rsp_ones[0]}, 64'd0);
        hang[0] = 1'b0;
        @(negedge clk);
        chk("to_cleared", {62'd0, rsp_valid[0], rsp_to[0]}, 64'd0);

        // Reset during WAIT of the 5th evaluation, then a fresh command.
        n0 = ntrig[0];
        run_cmd(0, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
        n = 0;
        while (ntrig[0] - n0 < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach5", 64'(ntrig[0] - n0), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  {63'd0, busy[0]},      64'd0);
        chk("mid_rst_ready", {63'd0, cmd_ready[0]}, 64'd1);
        chk("mid_rst_trig",  {63'd0, trig[0]},      64'd0);
        chk("mid_rst_rsp",   {51'd0, rsp_valid[0], rsp_xor[0], rsp_raw[0], rsp_ones[0], rsp_to[0]}, 64'd0);
        chk("mid_rst_ch",    pch[0] | pcfg[0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        set_pat(0, 15'h007F, 6'b100001, 6'b011110);
        n0 = ntrig[0];
        run_cmd(0, 64'h2222_2222_2222_2222, 64'h3);
        wait_rsp(0);
        chk("post_rst_ones",  {60'd0, rsp_ones[0]}, 64'd7);
        chk("post_rst_raw",   {58'd0, rsp_raw[0]},  64'h21);
        chk("post_rst_xor",   {63'd0, rsp_xor[0]},  64'd0);
        chk("post_rst_ntrig", 64'(ntrig[0] - n0),   64'd15);
        @(negedge clk);

        // GAP_CYCLES = 0.
        n0 = ntrig[1];
        run_cmd(1, 64'h4444_0000_4444_0000, 64'h4);
        wait_rsp(1);
        chk("gap0_ones",   {60'd0, rsp_ones[1]}, 64'd9);
        chk("gap0_raw",    {58'd0, rsp_raw[1]},  64'h2A);
        chk("gap0_sp_min", 64'(sp_min[1]), 64'd1);
        chk("gap0_sp_max", 64'(sp_max[1]), 64'd1);
        chk("gap0_ntrig",  64'(ntrig[1] - n0), 64'd15);
        @(negedge clk);

        // GAP_CYCLES = 3 with a spurious all-ones done in each gap.
        n0 = ntrig[2];
        run_cmd(2, 64'h3333_0000_3333_0000, 64'h5);
        wait_rsp(2);
        chk("gap3_xor",    {63'd0, rsp_xor[2]},  64'd1);
        chk("gap3_ones",   {60'd0, rsp_ones[2]}, 64'd9);
        chk("gap3_raw",    {58'd0, rsp_raw[2]},  64'h2A);
        chk("gap3_sp_min", 64'(sp_min[2]), 64'd4);
        chk("gap3_sp_max", 64'(sp_max[2]), 64'd4);
        chk("gap3_ntrig",  64'(ntrig[2] - n0), 64'd15);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
